// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: FSM states, access sizes and
// byte-lane mask constants, plus the alignment rule used by the top level.
package mem_access_unit_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  // Access size as carried on load_size_in; any value with bit 1 set is a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_NONE    = 4'b0000;
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    if (size[1]) begin
      mis = (offset != 2'b00);
    end else if (size == SZ_HALF) begin
      mis = offset[0];
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Replicates store data across byte lanes and builds the write byte mask
// for the requested size and address offset.
module store_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask
);

  always_comb begin
    data = rs2;
    mask = MASK_WORD;
    case (size)
      SZ_BYTE: begin
        data = {4{rs2[7:0]}};
        mask = MASK_BYTE0 << offset;
      end
      SZ_HALF: begin
        data = {2{rs2[15:0]}};
        mask = offset[1] ? MASK_HALF_HI : MASK_HALF_LO;
      end
      default: begin
        data = rs2;
        mask = MASK_WORD;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bridge between the execute stage and a single-outstanding data bus,
// with misalignment detection, ack timeout and a registered load-unit feed.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic [31:0] dmaddr_out,
  output logic [31:0] dmdata_out,
  output logic [3:0]  dmwr_mask_out,
  output logic        dmwr_req_out,
  output logic        dmrd_req_out,
  input  logic        dmack_in,
  input  logic [31:0] dmdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out,
  output logic        rvalid_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output state_t      state_dbg
);

  // Handshake: upstream presents a request and must hold every request input
  // while stall_out is high. The bus side sees a strobe held stable from the
  // cycle after acceptance until dmack_in is sampled high (or the timeout).
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic        req_valid;
  logic        req_mis;
  logic        accept;
  logic        ack_done;
  logic        timeout;
  logic        stall_raw;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [1:0]  pend_offset;
  logic [1:0]  pend_size;
  logic        pend_unsigned;

  assign req_valid = mem_wr_req_in | mem_rd_req_in;
  assign req_mis   = is_misaligned(load_size_in, iadder_in[1:0]);

  store_align u_store_align (
    .size   (load_size_in),
    .offset (iadder_in[1:0]),
    .rs2    (rs2_in),
    .data   (st_data),
    .mask   (st_mask)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_done || timeout) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    ack_done  = 1'b0;
    timeout   = 1'b0;
    stall_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        accept    = req_valid && !req_mis;
        stall_raw = req_valid && !req_mis;
      end
      ST_WAIT_ACK: begin
        ack_done  = dmack_in;
        // An ack in the final allowed cycle completes normally.
        timeout   = !dmack_in && (wait_cnt == WAIT_LAST);
        stall_raw = !dmack_in;
      end
      default: begin
        stall_raw = 1'b0;
      end
    endcase
  end

  // Gated so that every output reads zero while reset is held.
  assign stall_out = stall_raw & ~rst_in;
  assign state_dbg = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wait_cnt <= 8'd0;
    end else if (accept) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_WAIT_ACK && !dmack_in) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dmaddr_out     <= 32'd0;
      dmdata_out     <= 32'd0;
      dmwr_mask_out  <= MASK_NONE;
      dmwr_req_out   <= 1'b0;
      dmrd_req_out   <= 1'b0;
      pend_offset    <= 2'b00;
      pend_size      <= 2'b00;
      pend_unsigned  <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      misaligned_out <= (state == ST_IDLE) && req_valid && req_mis;
      bus_err_out    <= timeout;
      if (accept) begin
        // Write wins when both requests are present.
        dmaddr_out    <= {iadder_in[31:2], 2'b00};
        dmwr_req_out  <= mem_wr_req_in;
        dmrd_req_out  <= ~mem_wr_req_in;
        dmdata_out    <= mem_wr_req_in ? st_data : 32'd0;
        dmwr_mask_out <= mem_wr_req_in ? st_mask : MASK_NONE;
        pend_offset   <= iadder_in[1:0];
        pend_size     <= load_size_in;
        pend_unsigned <= load_unsigned_in;
      end else if (ack_done || timeout) begin
        dmwr_req_out <= 1'b0;
        dmrd_req_out <= 1'b0;
      end
    end
  end

  // Load-unit feed only changes when a read completes with an ack.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdata_out             <= 32'd0;
      iadder_out_1_to_0_out <= 2'b00;
      load_size_out         <= 2'b00;
      load_unsigned_out     <= 1'b0;
      rvalid_out            <= 1'b0;
    end else begin
      rvalid_out <= ack_done && dmrd_req_out;
      if (ack_done && dmrd_req_out) begin
        rdata_out             <= dmdata_in;
        iadder_out_1_to_0_out <= pend_offset;
        load_size_out         <= pend_size;
        load_unsigned_out     <= pend_unsigned;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases followed by
// random transactions, scored against an event-level reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;
  localparam int EW = 76;
  localparam logic [2:0] K_MIS  = 3'd1;
  localparam logic [2:0] K_BERR = 3'd2;
  localparam logic [2:0] K_RVAL = 3'd3;
  localparam logic [2:0] K_WR   = 3'd4;
  localparam logic [2:0] K_RD   = 3'd5;
  localparam logic [2:0] K_BAD  = 3'd7;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] iadder_in, rs2_in, dmdata_in;
  logic        mem_wr_req_in, mem_rd_req_in, load_unsigned_in, dmack_in;
  logic [1:0]  load_size_in;
  logic [31:0] dmaddr_out, dmdata_out, rdata_out;
  logic [3:0]  dmwr_mask_out;
  logic        dmwr_req_out, dmrd_req_out, stall_out;
  logic [1:0]  iadder_out_1_to_0_out, load_size_out;
  logic        load_unsigned_out, rvalid_out, misaligned_out, bus_err_out;
  state_t      state_dbg;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference view of the load-unit feed.
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_lo = 2'b00, m_sz = 2'b00;
  logic        m_uns = 1'b0;

  logic [31:0] obs_addr, obs_data;
  logic [3:0]  obs_mask;
  logic        obs_wr, obs_rd;
  int          last_stalls;

  mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .iadder_in(iadder_in), .rs2_in(rs2_in),
    .mem_wr_req_in(mem_wr_req_in), .mem_rd_req_in(mem_rd_req_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .dmaddr_out(dmaddr_out), .dmdata_out(dmdata_out), .dmwr_mask_out(dmwr_mask_out),
    .dmwr_req_out(dmwr_req_out), .dmrd_req_out(dmrd_req_out),
    .dmack_in(dmack_in), .dmdata_in(dmdata_in), .stall_out(stall_out),
    .rdata_out(rdata_out), .iadder_out_1_to_0_out(iadder_out_1_to_0_out),
    .load_size_out(load_size_out), .load_unsigned_out(load_unsigned_out),
    .rvalid_out(rvalid_out), .misaligned_out(misaligned_out),
    .bus_err_out(bus_err_out), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic pop_chk(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] want;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unexpected event %0h want none", name, got);
    end else begin
      want = exp_q.pop_front();
      chk(name, got, want);
    end
  endtask

  // Reference model of the access rules
  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic predict(input logic [31:0] rs2, input logic [1:0] sz, input logic [1:0] lo,
                         output logic [31:0] d, output logic [3:0] m);
    int bytes;
    bytes = size_bytes(sz);
    if (bytes == 1) begin
      d = {24'h0, rs2[7:0]} * 32'h01010101;
      m = 4'(1 << lo);
    end else if (bytes == 2) begin
      d = {16'h0, rs2[15:0]} * 32'h00010001;
      m = 4'(3 << lo);
    end else begin
      d = rs2;
      m = 4'hF;
    end
  endtask

  // Scoreboard: every output event is matched against the expected queue.
  logic          prev_strobe = 1'b0;
  logic [EW-1:0] snap;
  always @(negedge clk_in) begin : cmp
    logic [EW-1:0] bus_now;
    logic [2:0]    kind_now;
    logic          strobe;
    strobe   = dmwr_req_out | dmrd_req_out;
    kind_now = (dmwr_req_out && dmrd_req_out) ? K_BAD : dmwr_req_out ? K_WR : K_RD;
    bus_now  = {kind_now, dmaddr_out, dmwr_req_out ? dmdata_out : 32'h0, dmwr_mask_out, 5'b0};
    if (misaligned_out) pop_chk("misaligned_evt", {K_MIS, {(EW-3){1'b0}}});
    if (bus_err_out)    pop_chk("bus_err_evt", {K_BERR, {(EW-3){1'b0}}});
    if (rvalid_out)
      pop_chk("rvalid_evt", {K_RVAL, 32'h0, rdata_out, 4'h0, iadder_out_1_to_0_out,
                             load_size_out, load_unsigned_out});
    if (strobe && !prev_strobe) begin
      pop_chk("bus_start", bus_now);
      snap = bus_now;
    end else if (strobe) begin
      chk("bus_stable", bus_now, snap);
    end
    prev_strobe = strobe;
    chk("load_feed_hold", {rdata_out, iadder_out_1_to_0_out, load_size_out, load_unsigned_out},
        {m_rdata, m_lo, m_sz, m_uns});
  end

  // Drivers
  task automatic drop_req();
    mem_wr_req_in = 1'b0;
    mem_rd_req_in = 1'b0;
  endtask

  task automatic txn(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wdat, input logic [1:0] sz, input logic uns,
                     input int ack_wait, input logic [31:0] rdat);
    logic        mis, is_rd, timed, done, first;
    logic [31:0] pd;
    logic [3:0]  pm;
    int          n, stalls;
    mis   = (int'(addr[1:0]) % size_bytes(sz)) != 0;
    is_rd = rd && !wr;
    timed = (ack_wait >= TO);
    @(posedge clk_in); #1;
    mem_wr_req_in = wr; mem_rd_req_in = rd; iadder_in = addr; rs2_in = wdat;
    load_size_in = sz; load_unsigned_in = uns;
    if (mis) begin
      exp_q.push_back({K_MIS, {(EW-3){1'b0}}});
      @(negedge clk_in);
      chk("mis_stall", stall_out, 1'b0);
      @(posedge clk_in); #1;
      drop_req();
      @(negedge clk_in);
      chk("mis_pulse", {misaligned_out, dmwr_req_out, dmrd_req_out}, 3'b100);
    end else begin
      predict(wdat, sz, addr[1:0], pd, pm);
      if (wr) exp_q.push_back({K_WR, addr & 32'hFFFF_FFFC, pd, pm, 5'b0});
      else    exp_q.push_back({K_RD, addr & 32'hFFFF_FFFC, 32'h0, 4'h0, 5'b0});
      if (timed) exp_q.push_back({K_BERR, {(EW-3){1'b0}}});
      else if (is_rd) exp_q.push_back({K_RVAL, 32'h0, rdat, 4'h0, addr[1:0], sz, uns});
      stalls = 0;
      @(negedge clk_in);
      chk("accept_stall", stall_out, 1'b1);
      if (stall_out) stalls++;
      n = 0; done = 1'b0; first = 1'b1;
      while (!done) begin
        @(posedge clk_in); #1;
        if (n == ack_wait) begin dmack_in = 1'b1; dmdata_in = rdat; end
        else dmdata_in = $urandom;
        @(negedge clk_in);
        if (first) begin
          obs_addr = dmaddr_out; obs_data = dmdata_out; obs_mask = dmwr_mask_out;
          obs_wr = dmwr_req_out; obs_rd = dmrd_req_out; first = 1'b0;
        end
        chk("wait_stall", stall_out, !dmack_in);
        if (stall_out) stalls++;
        if (dmack_in) done = 1'b1;
        else begin
          n++;
          if (n == TO) done = 1'b1;
        end
      end
      @(posedge clk_in); #1;
      dmack_in = 1'b0;
      drop_req();
      if (!timed && is_rd) begin
        m_rdata = rdat; m_lo = addr[1:0]; m_sz = sz; m_uns = uns;
      end
      @(negedge clk_in);
      chk("post_idle", {dmwr_req_out, dmrd_req_out, stall_out, state_dbg}, {3'b000, ST_IDLE});
      chk("post_flags", {bus_err_out, rvalid_out}, {timed, is_rd && !timed});
      chk("stall_cycles", stalls, timed ? TO + 1 : ack_wait + 1);
      last_stalls = stalls;
    end
  endtask

  // Main sequence
  initial begin
    logic [31:0] pd;
    logic [3:0]  pm;
    rst_in = 1'b1;
    drop_req();
    iadder_in = 32'h0; rs2_in = 32'h0; load_size_in = 2'b00; load_unsigned_in = 1'b0;
    dmack_in = 1'b0; dmdata_in = 32'h0;
    repeat (2) @(negedge clk_in);
    chk("reset_bus", {dmaddr_out, dmdata_out, dmwr_mask_out, dmwr_req_out, dmrd_req_out}, '0);
    chk("reset_ctl", {stall_out, rvalid_out, misaligned_out, bus_err_out, iadder_out_1_to_0_out,
                      load_size_out, load_unsigned_out, state_dbg}, '0);
    chk("reset_rdata", rdata_out, 32'h0);
    iadder_in = 32'h40; load_size_in = 2'b10; mem_rd_req_in = 1'b1;
    #1 chk("reset_stall_gated", stall_out, 1'b0);
    drop_req();
    @(posedge clk_in); #1 rst_in = 1'b0;

    // Byte store at 0x103
    predict(32'hAABBCCDD, 2'b00, 2'b11, pd, pm);
    chk("model_byte_data", pd, 32'hDDDDDDDD);
    chk("model_byte_mask", pm, 4'b1000);
    txn(1'b1, 1'b0, 32'h103, 32'hAABBCCDD, 2'b00, 1'b0, 2, 32'h0);
    chk("byte_st_addr", obs_addr, 32'h100);
    chk("byte_st_data", obs_data, 32'hDDDDDDDD);
    chk("byte_st_mask", obs_mask, 4'b1000);
    chk("byte_st_strobes", {obs_wr, obs_rd}, 2'b10);

    // Half unsigned load at 0x202, ack in the fourth strobe cycle
    txn(1'b0, 1'b1, 32'h202, 32'h0, 2'b01, 1'b1, 3, 32'h12345678);
    chk("half_ld_rdata", rdata_out, 32'h12345678);
    chk("half_ld_ctl", {iadder_out_1_to_0_out, load_size_out, load_unsigned_out}, 5'b10_01_1);
    chk("half_ld_stalls", last_stalls, 4);
    @(negedge clk_in);
    chk("half_ld_rvalid_pulse", rvalid_out, 1'b0);

    // Misaligned word load
    txn(1'b0, 1'b1, 32'h301, 32'h0, 2'b10, 1'b0, 0, 32'h0);
    @(negedge clk_in);
    chk("mis_one_pulse", misaligned_out, 1'b0);

    // Read with no ack runs into the timeout; then ack exactly on the last cycle
    txn(1'b0, 1'b1, 32'h400, 32'h0, 2'b10, 1'b0, 99, 32'h0);
    chk("timeout_stalls", last_stalls, TO + 1);
    txn(1'b0, 1'b1, 32'h404, 32'h0, 2'b10, 1'b0, TO - 1, 32'hCAFEF00D);

    // Write and read together: write only
    txn(1'b1, 1'b1, 32'h506, 32'h11223344, 2'b01, 1'b0, 1, 32'h0);
    chk("wr_rd_strobes", {obs_wr, obs_rd}, 2'b10);
    chk("wr_rd_mask", obs_mask, 4'b1100);
    chk("wr_rd_data", obs_data, 32'h33443344);

    // Ack while idle is ignored
    @(posedge clk_in); #1 dmack_in = 1'b1; dmdata_in = 32'hDEADBEEF;
    repeat (3) @(posedge clk_in);
    #1 dmack_in = 1'b0;
    @(negedge clk_in);
    chk("idle_ack_ignored", {rvalid_out, state_dbg, dmrd_req_out}, {1'b0, ST_IDLE, 1'b0});

    // Reset in the middle of a read
    @(posedge clk_in); #1;
    mem_rd_req_in = 1'b1; iadder_in = 32'h600; load_size_in = 2'b10;
    exp_q.push_back({K_RD, 32'h600, 32'h0, 4'h0, 5'b0});
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    m_rdata = 32'h0; m_lo = 2'b00; m_sz = 2'b00; m_uns = 1'b0;
    #1 chk("rst_strobe_drop", {dmrd_req_out, dmwr_req_out, stall_out}, 3'b000);
    drop_req();
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(posedge clk_in); #1 dmack_in = 1'b1; dmdata_in = 32'h55AA55AA;
    @(posedge clk_in); #1 dmack_in = 1'b0;
    @(negedge clk_in);
    chk("rst_no_rvalid", {rvalid_out, rdata_out}, 33'h0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) rd = 1'b1;
      txn(wr, rd, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 5), $urandom);
    end

    repeat (3) @(negedge clk_in);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
